multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
// - Multi-cycle MIPS main control FSM; generates ALUOp (and all datapath strobes) consumed by ALUControl.
// - Decodes Opcode from the IR, sequences FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake.
// - Counts completed instructions for bring-up/debug.
// PARAMETERS
// - ALUOP_RTYPE  3'b111  ALUOp for R-type (ALUControl decodes funct)
// - ALUOP_ADD    3'b100  ALUOp for add (PC+4, branch target, address, ADDI)
// - ALUOP_OR     3'b101  ALUOp for ORI
// - ALUOP_BRANCH 3'b001  ALUOp for BEQ/BNE compare (subtract)
// - CNT_W        16      width of InstrCount
// PORTS
// - clk            in   1      clock, rising edge
// - reset          in   1      asynchronous, active-low reset
// - Opcode         in   6      IR[31:26]
// - MemReady       in   1      memory completes current access this cycle
// - PCWrite        out  1      unconditional PC load
// - PCWriteCond    out  1      PC load if ALU Zero (BEQ)
// - PCWriteCondNE  out  1      PC load if !Zero (BNE)
// - IorD           out  1      0=PC, 1=ALUOut as memory address
// - MemRead        out  1      memory read strobe
// - MemWrite       out  1      memory write strobe
// - IRWrite        out  1      load IR
// - MemtoReg       out  2      00=ALUOut, 01=MDR, 10=PC
// - RegDst         out  2      00=rt, 01=rd, 10=$31
// - RegWrite       out  1      register file write
// - ALUSrcA        out  1      0=PC, 1=A
// - ALUSrcB        out  2      00=B, 01=4, 10=signext imm, 11=signext imm<<2
// - ALUOp          out  3      to ALUControl
// - PCSource       out  2      00=ALU, 01=ALUOut, 10=jump target
// - IllegalOp      out  1      one-cycle pulse on unsupported opcode
// - State          out  4      current state (debug)
// - InstrCount     out  CNT_W  completed instructions, wraps
// BEHAVIOUR
// - Moore outputs decoded from State; unlisted outputs 0 in every state. ALUOp=ALUOP_ADD where unlisted.
// - reset low: State=IDLE, all outputs 0, InstrCount=0, op_q=0, immediately; IDLE->FETCH next clk.
// - 0 IDLE: all 0 -> FETCH.
// - 1 FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=MemReady; hold while MemReady=0, else -> DECODE.
// - 2 DECODE: op_q<=Opcode; ALUSrcB=11. Next by Opcode: 0x00 R_EXEC; 0x23/0x2B MEM_ADDR;
//   0x04/0x05 BRANCH; 0x08/0x0D I_EXEC; 0x02 JUMP; 0x03 see CONFIGURATION; else ILLEGAL.
// - 3 MEM_ADDR: ALUSrcA=1, ALUSrcB=10 -> MEM_READ (op_q=0x23) / MEM_WRITE (0x2B).
// - 4 MEM_READ: MemRead=1, IorD=1; hold until MemReady -> LW_WB.
// - 5 LW_WB: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
// - 6 MEM_WRITE: MemWrite=1, IorD=1; hold until MemReady -> FETCH.
// - 7 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=ALUOP_RTYPE -> R_WB.   8 R_WB: RegWrite=1, RegDst=01 -> FETCH.
// - 9 BRANCH: ALUSrcA=1, ALUOp=ALUOP_BRANCH, PCSource=01; PCWriteCond=(op_q==0x04),
//   PCWriteCondNE=(op_q==0x05) -> FETCH.
// - 10 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD (0x08) / OR (0x0D) -> 11 I_WB: RegWrite=1, RegDst=00 -> FETCH.
// - 12 JUMP: PCWrite=1, PCSource=10 -> FETCH.
// - 13 JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH.
// - 14 ILLEGAL: IllegalOp=1 -> FETCH.  Codes 15 unused: -> IDLE.
// - Decisions after DECODE use op_q only; Opcode changes after DECODE ignored.
// - InstrCount +1 on each transition into FETCH from states 5,6,8,9,11,12,13; not from IDLE/ILLEGAL; wraps to 0.
// - MemReady ignored outside FETCH/MEM_READ/MEM_WRITE. Reset mid-instruction abandons it, no count.
// CONFIGURATION
// - CONTROL_JAL_EN defined: Opcode 0x03 in DECODE -> JAL (state 13).
// - CONTROL_JAL_EN undefined: 0x03 -> ILLEGAL; state 13 unreachable; RegDst=10 and MemtoReg=10 never driven.
// TESTING
// - reset=0 during MEM_WRITE -> State=0, MemWrite=0, InstrCount=0 same cycle; release -> FETCH after 1 clk.
// - Opcode=0x00, MemReady=1 -> States 1,2,7,8,1; ALUOp=111 in 7; RegWrite=1,RegDst=01 in 8; InstrCount 0->1.
// - Opcode=0x23, MemReady=0 for 3 clks in MEM_READ -> State=4 held 4 clks, MemRead=1,IorD=1; LW_WB MemtoReg=01.
// - Opcode=0x05 -> BRANCH: PCWriteCondNE=1, PCWriteCond=0, ALUOp=001, PCSource=01; Opcode changed to 0x04 in state 9 -> no effect.
// - Opcode=0x0D -> I_EXEC ALUOp=101; Opcode=0x3F -> ILLEGAL, IllegalOp=1 for 1 clk, InstrCount unchanged.
// - Opcode=0x03: CONTROL_JAL_EN set -> State 13, RegDst=10, MemtoReg=10, PCWrite=1; unset -> ILLEGAL pulse.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Opcode/handshake inputs and datapath strobes of the multi-cycle
//            MIPS main control unit, bundled with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCWriteCondNE;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       MemtoReg;
    logic [1:0]       RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             IllegalOp;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    // Control-unit side
    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State, InstrCount
    );

    // Datapath / memory side
    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State, InstrCount
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle MIPS main control FSM with retired-instruction
//            counter. Define CONTROL_JAL_EN to decode opcode 0x03 as JAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter logic [2:0] ALUOP_RTYPE  = 3'b111,
    parameter logic [2:0] ALUOP_ADD    = 3'b100,
    parameter logic [2:0] ALUOP_OR     = 3'b101,
    parameter logic [2:0] ALUOP_BRANCH = 3'b001,
    parameter int         CNT_W        = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    multicycle_control_if.master   bus
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_FETCH     = 4'd1;
    localparam logic [3:0] c_DECODE    = 4'd2;
    localparam logic [3:0] c_MEM_ADDR  = 4'd3;
    localparam logic [3:0] c_MEM_READ  = 4'd4;
    localparam logic [3:0] c_LW_WB     = 4'd5;
    localparam logic [3:0] c_MEM_WRITE = 4'd6;
    localparam logic [3:0] c_R_EXEC    = 4'd7;
    localparam logic [3:0] c_R_WB      = 4'd8;
    localparam logic [3:0] c_BRANCH    = 4'd9;
    localparam logic [3:0] c_I_EXEC    = 4'd10;
    localparam logic [3:0] c_I_WB      = 4'd11;
    localparam logic [3:0] c_JUMP      = 4'd12;
    localparam logic [3:0] c_JAL       = 4'd13;
    localparam logic [3:0] c_ILLEGAL   = 4'd14;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_count;
    logic             w_count_en;

    logic             w_pc_write, w_pc_write_cond, w_pc_write_cond_ne;
    logic             w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic [1:0]       w_mem_to_reg, w_reg_dst;
    logic             w_reg_write, w_alu_src_a;
    logic [1:0]       w_alu_src_b, w_pc_source;
    logic [2:0]       w_alu_op;
    logic             w_illegal;

    // State register plus the latched opcode and the retired-instruction count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_op    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_DECODE) r_op <= bus.Opcode;
            if (w_count_en)          r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE:      w_next = c_FETCH;
            c_FETCH:     w_next = bus.MemReady ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (bus.Opcode)
                    c_OP_RTYPE:         w_next = c_R_EXEC;
                    c_OP_LW, c_OP_SW:   w_next = c_MEM_ADDR;
                    c_OP_BEQ, c_OP_BNE: w_next = c_BRANCH;
                    c_OP_ADDI, c_OP_ORI: w_next = c_I_EXEC;
                    c_OP_J:             w_next = c_JUMP;
`ifdef CONTROL_JAL_EN
                    c_OP_JAL:           w_next = c_JAL;
`else
                    c_OP_JAL:           w_next = c_ILLEGAL;
`endif
                    default:            w_next = c_ILLEGAL;
                endcase
            end
            c_MEM_ADDR:  w_next = (r_op == c_OP_SW) ? c_MEM_WRITE : c_MEM_READ;
            c_MEM_READ:  w_next = bus.MemReady ? c_LW_WB : c_MEM_READ;
            c_LW_WB:     w_next = c_FETCH;
            c_MEM_WRITE: w_next = bus.MemReady ? c_FETCH : c_MEM_WRITE;
            c_R_EXEC:    w_next = c_R_WB;
            c_R_WB:      w_next = c_FETCH;
            c_BRANCH:    w_next = c_FETCH;
            c_I_EXEC:    w_next = c_I_WB;
            c_I_WB:      w_next = c_FETCH;
            c_JUMP:      w_next = c_FETCH;
`ifdef CONTROL_JAL_EN
            c_JAL:       w_next = c_FETCH;
`endif
            c_ILLEGAL:   w_next = c_FETCH;
            default:     w_next = c_IDLE;
        endcase
    end

    // Only a completing instruction returns to FETCH from these states
    assign w_count_en = (w_next == c_FETCH) &&
                        (r_state inside {c_LW_WB, c_MEM_WRITE, c_R_WB, c_BRANCH,
                                         c_I_WB, c_JUMP, c_JAL});

    always_comb begin
        w_pc_write         = 1'b0;
        w_pc_write_cond    = 1'b0;
        w_pc_write_cond_ne = 1'b0;
        w_iord             = 1'b0;
        w_mem_read         = 1'b0;
        w_mem_write        = 1'b0;
        w_ir_write         = 1'b0;
        w_mem_to_reg       = 2'b00;
        w_reg_dst          = 2'b00;
        w_reg_write        = 1'b0;
        w_alu_src_a        = 1'b0;
        w_alu_src_b        = 2'b00;
        w_alu_op           = ALUOP_ADD;
        w_pc_source        = 2'b00;
        w_illegal          = 1'b0;
        case (r_state)
            c_IDLE:      w_alu_op = 3'b000;
            c_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.MemReady;
                w_pc_write  = bus.MemReady;
            end
            c_DECODE:    w_alu_src_b = 2'b11;
            c_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            c_LW_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 2'b01;
            end
            c_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            c_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_RTYPE;
            end
            c_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 2'b01;
            end
            c_BRANCH: begin
                w_alu_src_a        = 1'b1;
                w_alu_op           = ALUOP_BRANCH;
                w_pc_source        = 2'b01;
                w_pc_write_cond    = (r_op == c_OP_BEQ);
                w_pc_write_cond_ne = (r_op == c_OP_BNE);
            end
            c_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = (r_op == c_OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            c_I_WB:      w_reg_write = 1'b1;
            c_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
`ifdef CONTROL_JAL_EN
            c_JAL: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_reg_write  = 1'b1;
                w_reg_dst    = 2'b10;
                w_mem_to_reg = 2'b10;
            end
`endif
            c_ILLEGAL:   w_illegal = 1'b1;
            default:     w_alu_op  = 3'b000;
        endcase
    end

    assign bus.PCWrite       = w_pc_write;
    assign bus.PCWriteCond   = w_pc_write_cond;
    assign bus.PCWriteCondNE = w_pc_write_cond_ne;
    assign bus.IorD          = w_iord;
    assign bus.MemRead       = w_mem_read;
    assign bus.MemWrite      = w_mem_write;
    assign bus.IRWrite       = w_ir_write;
    assign bus.MemtoReg      = w_mem_to_reg;
    assign bus.RegDst        = w_reg_dst;
    assign bus.RegWrite      = w_reg_write;
    assign bus.ALUSrcA       = w_alu_src_a;
    assign bus.ALUSrcB       = w_alu_src_b;
    assign bus.ALUOp         = w_alu_op;
    assign bus.PCSource      = w_pc_source;
    assign bus.IllegalOp     = w_illegal;
    assign bus.State         = r_state;
    assign bus.InstrCount    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control: directed scenarios
//            plus random instruction streams against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   m_path[$];

    multicycle_control_if #(.CNT_W(16)) bus ();

    multicycle_control #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNE, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                bus.IllegalOp};
    endfunction

    // Output table of the control unit, one row per state
    function automatic logic [20:0] exp_out(input int s, input logic [5:0] opq, input logic mr);
        logic pw = 0, pwc = 0, pwne = 0, iord = 0, mrd = 0, mw = 0, irw = 0;
        logic rw = 0, asa = 0, ill = 0;
        logic [1:0] m2r = 0, rd = 0, asb = 0, pcs = 0;
        logic [2:0] aop = 3'b100;
        case (s)
            0:  aop = 3'b000;
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 2'b01; end
            6:  begin mw = 1; iord = 1; end
            7:  begin asa = 1; aop = 3'b111; end
            8:  begin rw = 1; rd = 2'b01; end
            9:  begin asa = 1; aop = 3'b001; pcs = 2'b01; pwc = (opq == 6'h04); pwne = (opq == 6'h05); end
            10: begin asa = 1; asb = 2'b10; aop = (opq == 6'h0D) ? 3'b101 : 3'b100; end
            11: rw = 1;
            12: begin pw = 1; pcs = 2'b10; end
            13: begin pw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            14: ill = 1;
            default: aop = 3'b000;
        endcase
        return {pw, pwc, pwne, iord, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Sequence of states an instruction visits, and whether it retires
    task automatic plan(input logic [5:0] op, output bit retires);
        m_path = {1, 2};
        retires = 1'b1;
        case (op)
            6'h00:        begin m_path.push_back(7); m_path.push_back(8); end
            6'h23:        begin m_path.push_back(3); m_path.push_back(4); m_path.push_back(5); end
            6'h2B:        begin m_path.push_back(3); m_path.push_back(6); end
            6'h04, 6'h05: m_path.push_back(9);
            6'h08, 6'h0D: begin m_path.push_back(10); m_path.push_back(11); end
            6'h02:        m_path.push_back(12);
`ifdef CONTROL_JAL_EN
            6'h03:        m_path.push_back(13);
`endif
            default:      begin m_path.push_back(14); retires = 1'b0; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        #1;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.Opcode = 6'h00;
        bus.MemReady = 1'b0;
        #3;
        total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.State); end
        total++; if (obs() !== 21'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs()); end
        total++; if (bus.InstrCount !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.InstrCount); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
        #1;
        total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL reset_to_fetch: got %0d want 1", bus.State); end
    endtask

    task automatic test_rtype();
        reset_dut();
        bus.Opcode = 6'h00;
        bus.MemReady = 1'b1;
        tick(); #1;
        total++; if (bus.State !== 4'd1 || bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
            bad++; $display("FAIL rtype_fetch: got st=%0d irw=%b pcw=%b want 1 1 1", bus.State, bus.IRWrite, bus.PCWrite); end
        tick(); #1;
        total++; if (bus.State !== 4'd2) begin bad++; $display("FAIL rtype_decode: got %0d want 2", bus.State); end
        tick(); #1;
        total++; if (bus.State !== 4'd7 || bus.ALUOp !== 3'b111) begin
            bad++; $display("FAIL rtype_exec: got st=%0d aluop=%b want 7 111", bus.State, bus.ALUOp); end
        tick(); #1;
        total++; if (bus.State !== 4'd8 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b01 || bus.InstrCount !== 16'd0) begin
            bad++; $display("FAIL rtype_wb: got st=%0d rw=%b rd=%b cnt=%0d want 8 1 01 0", bus.State, bus.RegWrite, bus.RegDst, bus.InstrCount); end
        tick(); #1;
        total++; if (bus.State !== 4'd1 || bus.InstrCount !== 16'd1) begin
            bad++; $display("FAIL rtype_retire: got st=%0d cnt=%0d want 1 1", bus.State, bus.InstrCount); end
    endtask

    task automatic test_lw_wait();
        reset_dut();
        bus.Opcode = 6'h23;
        bus.MemReady = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = (i == 3);
            #1;
            total++; if (bus.State !== 4'd4 || bus.MemRead !== 1'b1 || bus.IorD !== 1'b1) begin
                bad++; $display("FAIL lw_wait%0d: got st=%0d mr=%b iord=%b want 4 1 1", i, bus.State, bus.MemRead, bus.IorD); end
            tick();
        end
        #1;
        total++; if (bus.State !== 4'd5 || bus.MemtoReg !== 2'b01 || bus.RegWrite !== 1'b1) begin
            bad++; $display("FAIL lw_wb: got st=%0d m2r=%b rw=%b want 5 01 1", bus.State, bus.MemtoReg, bus.RegWrite); end
    endtask

    task automatic test_branch();
        reset_dut();
        bus.Opcode = 6'h05;
        bus.MemReady = 1'b1;
        repeat (3) tick();
        bus.Opcode = 6'h04;
        #1;
        total++; if (bus.State !== 4'd9 || bus.PCWriteCondNE !== 1'b1 || bus.PCWriteCond !== 1'b0 ||
                     bus.ALUOp !== 3'b001 || bus.PCSource !== 2'b01) begin
            bad++; $display("FAIL bne: got st=%0d ne=%b eq=%b aluop=%b pcs=%b want 9 1 0 001 01",
                            bus.State, bus.PCWriteCondNE, bus.PCWriteCond, bus.ALUOp, bus.PCSource); end
        tick(); #1;
        total++; if (bus.State !== 4'd1 || bus.InstrCount !== 16'd1) begin
            bad++; $display("FAIL bne_retire: got st=%0d cnt=%0d want 1 1", bus.State, bus.InstrCount); end
    endtask

    task automatic test_ori_illegal();
        reset_dut();
        bus.Opcode = 6'h0D;
        bus.MemReady = 1'b1;
        repeat (3) tick();
        #1;
        total++; if (bus.State !== 4'd10 || bus.ALUOp !== 3'b101) begin
            bad++; $display("FAIL ori_exec: got st=%0d aluop=%b want 10 101", bus.State, bus.ALUOp); end
        repeat (2) tick();
        bus.Opcode = 6'h3F;
        repeat (2) tick();
        #1;
        total++; if (bus.State !== 4'd14 || bus.IllegalOp !== 1'b1) begin
            bad++; $display("FAIL illegal: got st=%0d ill=%b want 14 1", bus.State, bus.IllegalOp); end
        tick(); #1;
        total++; if (bus.State !== 4'd1 || bus.IllegalOp !== 1'b0 || bus.InstrCount !== 16'd1) begin
            bad++; $display("FAIL illegal_after: got st=%0d ill=%b cnt=%0d want 1 0 1", bus.State, bus.IllegalOp, bus.InstrCount); end
    endtask

    task automatic test_jal();
        logic [15:0] want_cnt;
        reset_dut();
        bus.Opcode = 6'h03;
        bus.MemReady = 1'b1;
        repeat (3) tick();
        #1;
`ifdef CONTROL_JAL_EN
        want_cnt = 16'd1;
        total++; if (bus.State !== 4'd13 || bus.RegDst !== 2'b10 || bus.MemtoReg !== 2'b10 || bus.PCWrite !== 1'b1) begin
            bad++; $display("FAIL jal: got st=%0d rd=%b m2r=%b pcw=%b want 13 10 10 1", bus.State, bus.RegDst, bus.MemtoReg, bus.PCWrite); end
`else
        want_cnt = 16'd0;
        total++; if (bus.State !== 4'd14 || bus.IllegalOp !== 1'b1 || bus.RegDst !== 2'b00 || bus.MemtoReg !== 2'b00) begin
            bad++; $display("FAIL jal_disabled: got st=%0d ill=%b rd=%b m2r=%b want 14 1 00 00", bus.State, bus.IllegalOp, bus.RegDst, bus.MemtoReg); end
`endif
        tick(); #1;
        total++; if (bus.State !== 4'd1 || bus.InstrCount !== want_cnt) begin
            bad++; $display("FAIL jal_retire: got st=%0d cnt=%0d want 1 %0d", bus.State, bus.InstrCount, want_cnt); end
    endtask

    task automatic test_reset_mid_write();
        reset_dut();
        bus.Opcode = 6'h00;
        bus.MemReady = 1'b1;
        repeat (5) tick();
        bus.Opcode = 6'h2B;
        repeat (3) tick();
        bus.MemReady = 1'b0;
        #1;
        total++; if (bus.State !== 4'd6 || bus.MemWrite !== 1'b1 || bus.InstrCount !== 16'd1) begin
            bad++; $display("FAIL sw_wait: got st=%0d mw=%b cnt=%0d want 6 1 1", bus.State, bus.MemWrite, bus.InstrCount); end
        reset = 1'b0;
        #1;
        total++; if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0 || bus.InstrCount !== 16'd0) begin
            bad++; $display("FAIL async_reset: got st=%0d mw=%b cnt=%0d want 0 0 0", bus.State, bus.MemWrite, bus.InstrCount); end
        tick();
        reset = 1'b1;
        tick(); #1;
        total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL reset_release: got %0d want 1", bus.State); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03};
        logic [5:0]  op;
        logic [15:0] model_cnt;
        logic        mr;
        bit          retires;
        bit          done;
        int          waits;
        int          st;
        reset_dut();
        model_cnt = 16'd0;
        bus.MemReady = 1'($urandom);
        bus.Opcode = 6'($urandom);
        #1;
        total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL rand_idle: got %0d want 0", bus.State); end
        tick();
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            plan(op, retires);
            foreach (m_path[k]) begin
                st = m_path[k];
                waits = 0;
                done = 1'b0;
                while (!done) begin
                    mr = (waits >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                    bus.MemReady = mr;
                    bus.Opcode = (st == 2) ? op : 6'($urandom);
                    #1;
                    total++;
                    if (bus.State !== 4'(st) || obs() !== exp_out(st, op, mr) || bus.InstrCount !== model_cnt) begin
                        bad++;
                        $display("FAIL rand op=%h: got st=%0d out=%h cnt=%0d want st=%0d out=%h cnt=%0d",
                                 op, bus.State, obs(), bus.InstrCount, st, exp_out(st, op, mr), model_cnt);
                    end
                    tick();
                    waits++;
                    done = !(st == 1 || st == 4 || st == 6) || mr;
                end
            end
            if (retires) model_cnt = model_cnt + 16'd1;
        end
        #1;
        total++; if (bus.State !== 4'd1 || bus.InstrCount !== model_cnt) begin
            bad++; $display("FAIL rand_final: got st=%0d cnt=%0d want 1 %0d", bus.State, bus.InstrCount, model_cnt); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_ori_illegal();
        test_jal();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
